ycr1_imem_wb_bridge: RTL and testbench

YCR1_IMEM_WB_BRIDGE -- requirements
Module: ycr1_imem_wb_bridge

---
 rtl/ycr1_imem_wb_bridge_pkg.sv | 62 ++++++
 rtl/ycr1_imem_req_fifo.sv | 67 ++++++
 rtl/ycr1_imem_wb_bridge.sv | 184 ++++++++++++++++++
 tb/tb_ycr1_imem_wb_bridge.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ycr1_imem_wb_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ycr1_imem_wb_bridge_pkg
// Description : Shared memory-interface encodings and the bridge FSM, result
//               and request-entry types used by the IMEM-to-Wishbone bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package ycr1_imem_wb_bridge_pkg;

  // Core instruction-memory port widths
  localparam int YCR1_IMEM_AWIDTH     = 32;
  localparam int YCR1_IMEM_DWIDTH     = 32;

  // Depth of the request FIFO between the router port and the WB master
  localparam int YCR1_IMEM_FIFO_DEPTH = 2;

  // Memory command encoding
  typedef enum logic {
    YCR1_MEM_CMD_RD = 1'b0,
    YCR1_MEM_CMD_WR = 1'b1
  } type_ycr1_mem_cmd_e;

  // Memory response encoding
  typedef enum logic [1:0] {
    YCR1_MEM_RESP_NOTRDY = 2'b00,
    YCR1_MEM_RESP_RDY_OK = 2'b01,
    YCR1_MEM_RESP_RDY_ER = 2'b10
  } type_ycr1_mem_resp_e;

  // Bridge control states
  typedef enum logic [1:0] {
    BR_IDLE = 2'd0,
    BR_BUS  = 2'd1,
    BR_RESP = 2'd2
  } ycr1_imem_br_state_e;

  // Outcome of one fetch, held until the response cycle
  typedef enum logic {
    BR_RES_OK = 1'b0,
    BR_RES_ER = 1'b1
  } ycr1_imem_br_result_e;

  // One queued request: fetch address plus "answer with error" flag
  typedef struct packed {
    logic [YCR1_IMEM_AWIDTH-1:0] addr;
    logic                        err;
  } ycr1_imem_req_s;

  localparam int YCR1_IMEM_REQ_W = $bits(ycr1_imem_req_s);

  // Eight-bit increment that sticks at all-ones
  function automatic logic [7:0] ycr1_sat_inc8(input logic [7:0] val);
    return (val == 8'hFF) ? val : val + 8'd1;
  endfunction

  // Map an internal result onto the core response encoding
  function automatic logic [1:0] ycr1_resp_encode(input ycr1_imem_br_result_e res);
    return (res == BR_RES_OK) ? YCR1_MEM_RESP_RDY_OK : YCR1_MEM_RESP_RDY_ER;
  endfunction

endpackage : ycr1_imem_wb_bridge_pkg
`default_nettype wire

// File: rtl/ycr1_imem_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ycr1_imem_req_fifo
// Description : Small in-order request FIFO with registered head, no bypass.
//               Pushes while full and pops while empty are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module ycr1_imem_req_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      cnt_q;

  logic             push_ok;
  logic             pop_ok;

  assign full_o     = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign push_ok    = push_i & ~full_o;
  assign pop_ok     = pop_i & ~empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];

  // Storage array: written at the tail, no reset needed since reads are gated by empty
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointers and occupancy, wrapping at DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= (wr_ptr_q == PW'(DEPTH-1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= (rd_ptr_q == PW'(DEPTH-1)) ? '0 : rd_ptr_q + PW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule : ycr1_imem_req_fifo
`default_nettype wire

// File: rtl/ycr1_imem_wb_bridge.sv
`default_nettype none
// ============================================================================
// Module      : ycr1_imem_wb_bridge
// Description : Instruction-memory router port to Wishbone classic master.
//               Requests are queued in order, issued one at a time on WB and
//               answered with a single-cycle response. Writes are refused
//               with an error, and a stalled slave is aborted after
//               TIMEOUT_CYC cycles (0 disables the abort).
// Revision    : 1.0 - initial release
// ============================================================================
module ycr1_imem_wb_bridge
  import ycr1_imem_wb_bridge_pkg::*;
#(
  parameter logic [7:0] TIMEOUT_CYC = 8'd255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  // Router-side instruction memory port
  input  logic                        imem_req,
  output logic                        imem_req_ack,
  input  logic                        imem_cmd,
  input  logic [YCR1_IMEM_AWIDTH-1:0] imem_addr,
  output logic [YCR1_IMEM_DWIDTH-1:0] imem_rdata,
  output logic [1:0]                  imem_resp,
  // Wishbone master
  output logic                        wbm_cyc_o,
  output logic                        wbm_stb_o,
  output logic [31:0]                 wbm_adr_o,
  output logic                        wbm_we_o,
  output logic [3:0]                  wbm_sel_o,
  input  logic [31:0]                 wbm_dat_i,
  input  logic                        wbm_ack_i,
  input  logic                        wbm_err_i
);

  ycr1_imem_br_state_e         state_q, state_d;
  ycr1_imem_br_result_e        result_q, result_d;
  logic [YCR1_IMEM_DWIDTH-1:0] rdata_q, rdata_d;
  // Number of strobe cycles already spent on the current WB access
  logic [7:0]                  cnt_q, cnt_d;

  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        fifo_push;
  logic                        fifo_pop;
  ycr1_imem_req_s              push_entry;
  ycr1_imem_req_s              head;
  logic                        bus_stb;
  logic                        tmo_hit;

  // ---------------------------------------------------------------------------
  // Request queue
  // ---------------------------------------------------------------------------
  assign imem_req_ack     = ~fifo_full;
  assign fifo_push        = imem_req & imem_req_ack;
  assign push_entry.addr  = imem_addr;
  assign push_entry.err   = (imem_cmd != YCR1_MEM_CMD_RD);

  ycr1_imem_req_fifo #(
    .WIDTH (YCR1_IMEM_REQ_W),
    .DEPTH (YCR1_IMEM_FIFO_DEPTH)
  ) u_req_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (fifo_push),
    .push_data_i (push_entry),
    .pop_i       (fifo_pop),
    .pop_data_o  (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Abort only when enabled; the count is checked before it advances
  assign tmo_hit = (TIMEOUT_CYC != 8'd0) && (cnt_q == TIMEOUT_CYC);

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------

  // State, result, captured data and timeout counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BR_IDLE;
      result_q <= BR_RES_OK;
      rdata_q  <= '0;
      cnt_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic; the strobe comes up combinationally in IDLE so that a
  // zero-wait slave can terminate in the very first bus cycle
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    bus_stb  = 1'b0;
    fifo_pop = 1'b0;

    case (state_q)
      BR_IDLE: begin
        if (!fifo_empty) begin
          if (head.err) begin
            // Non-read command: answer with an error, never touch the bus
            result_d = BR_RES_ER;
            rdata_d  = '0;
            state_d  = BR_RESP;
          end else begin
            bus_stb = 1'b1;
            if (wbm_err_i) begin
              result_d = BR_RES_ER;
              rdata_d  = '0;
              state_d  = BR_RESP;
            end else if (wbm_ack_i) begin
              result_d = BR_RES_OK;
              rdata_d  = wbm_dat_i;
              state_d  = BR_RESP;
            end else begin
              // Counter restarts; this launch cycle is the first one spent
              cnt_d   = 8'd1;
              state_d = BR_BUS;
            end
          end
        end
      end

      BR_BUS: begin
        bus_stb = 1'b1;
        cnt_d   = ycr1_sat_inc8(cnt_q);
        if (wbm_err_i) begin
          result_d = BR_RES_ER;
          rdata_d  = '0;
          state_d  = BR_RESP;
        end else if (wbm_ack_i) begin
          result_d = BR_RES_OK;
          rdata_d  = wbm_dat_i;
          state_d  = BR_RESP;
        end else if (tmo_hit) begin
          result_d = BR_RES_ER;
          rdata_d  = '0;
          state_d  = BR_RESP;
        end
      end

      BR_RESP: begin
        // Response is on the port this cycle; retire the head entry
        fifo_pop = 1'b1;
        state_d  = BR_IDLE;
      end

      default: begin
        state_d = BR_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------

  // Response port: only live during the single RESP cycle
  always_comb begin
    imem_resp  = YCR1_MEM_RESP_NOTRDY;
    imem_rdata = '0;
    if (state_q == BR_RESP) begin
      imem_resp  = ycr1_resp_encode(result_q);
      imem_rdata = rdata_q;
    end
  end

  // Head address is stable for the whole access since the FIFO only pops in RESP
  assign wbm_cyc_o = bus_stb;
  assign wbm_stb_o = bus_stb;
  assign wbm_adr_o = bus_stb ? head.addr : 32'd0;
  assign wbm_we_o  = 1'b0;
  assign wbm_sel_o = 4'hF;

endmodule : ycr1_imem_wb_bridge
`default_nettype wire

// File: tb/tb_ycr1_imem_wb_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_ycr1_imem_wb_bridge
// Description : Self-checking bench for ycr1_imem_wb_bridge: a table of single
//               fetches plus hand-written back-to-back, back-pressure, reset
//               and disabled-timeout sequences, checked through a response
//               scoreboard and a scripted Wishbone slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ycr1_imem_wb_bridge;

  localparam logic [1:0] RESP_NOTRDY = 2'b00;
  localparam logic [1:0] RESP_OK     = 2'b01;
  localparam logic [1:0] RESP_ER     = 2'b10;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;

  // Main DUT (abort after 4 cycles)
  logic        imem_req = 1'b0;
  logic        imem_cmd = 1'b0;
  logic [31:0] imem_addr = 32'd0;
  logic        imem_req_ack;
  logic [31:0] imem_rdata;
  logic [1:0]  imem_resp;
  logic        wbm_cyc, wbm_stb, wbm_we;
  logic [31:0] wbm_adr;
  logic [3:0]  wbm_sel;
  logic [31:0] wbm_dat = 32'd0;
  logic        wbm_ack = 1'b0;
  logic        wbm_err = 1'b0;

  // Second DUT with the abort disabled, slave never answers
  logic        z_req = 1'b0;
  logic        z_cmd = 1'b0;
  logic [31:0] z_addr = 32'd0;
  logic        z_req_ack;
  logic [31:0] z_rdata;
  logic [1:0]  z_resp;
  logic        z_cyc, z_stb, z_we;
  logic [31:0] z_adr;
  logic [3:0]  z_sel;
  logic [31:0] z_dat = 32'd0;
  logic        z_ack = 1'b0;
  logic        z_err = 1'b0;

  ycr1_imem_wb_bridge #(.TIMEOUT_CYC(8'd4)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_req_ack (imem_req_ack),
    .imem_cmd     (imem_cmd),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .wbm_cyc_o    (wbm_cyc),
    .wbm_stb_o    (wbm_stb),
    .wbm_adr_o    (wbm_adr),
    .wbm_we_o     (wbm_we),
    .wbm_sel_o    (wbm_sel),
    .wbm_dat_i    (wbm_dat),
    .wbm_ack_i    (wbm_ack),
    .wbm_err_i    (wbm_err)
  );

  ycr1_imem_wb_bridge #(.TIMEOUT_CYC(8'd0)) u_dut0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (z_req),
    .imem_req_ack (z_req_ack),
    .imem_cmd     (z_cmd),
    .imem_addr    (z_addr),
    .imem_rdata   (z_rdata),
    .imem_resp    (z_resp),
    .wbm_cyc_o    (z_cyc),
    .wbm_stb_o    (z_stb),
    .wbm_adr_o    (z_adr),
    .wbm_we_o     (z_we),
    .wbm_sel_o    (z_sel),
    .wbm_dat_i    (z_dat),
    .wbm_ack_i    (z_ack),
    .wbm_err_i    (z_err)
  );

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          acc;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          dly;
    logic        ack;
    logic        err;
    logic [31:0] data;
  } slv_t;

  typedef struct {
    logic        cmd;
    logic [31:0] addr;
    int          dly;
    logic        ack;
    logic        err;
    logic [31:0] data;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_stb;
  } vec_t;

  exp_t exp_q[$];
  slv_t slv_q[$];
  vec_t vt[8];

  int   n_cmp        = 0;
  int   n_mis        = 0;
  int   cyc_n        = 0;
  int   last_stb_len = 0;
  int   n_resp_seen  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Drive one request, wait (bounded) for acceptance, queue its expected answer
  task automatic send(input logic cmd, input logic [31:0] addr, input logic [1:0] er,
                      input logic [31:0] ed, input int lat, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    imem_req  = 1'b1;
    imem_cmd  = cmd;
    imem_addr = addr;
    while (!imem_req_ack && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req_ack) begin
      n_cmp++;
      n_mis++;
      $display("FAIL accept_timeout: req_ack stayed 0, want 1 within 50 cycles (addr 0x%08h)", addr);
      imem_req = 1'b0;
      acc = -1;
    end else begin
      acc = cyc_n;
      exp_q.push_back('{resp: er, rdata: ed, acc: cyc_n, lat: lat});
      @(posedge clk);
      #1 imem_req = 1'b0;
    end
  endtask

  // Wait (bounded) until every expected response has been seen
  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL drain_timeout: %0d responses outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  // Scripted Wishbone slave for the main DUT
  slv_t cur;
  int   stbcnt;
  logic active;
  initial begin
    active = 1'b0;
    stbcnt = 0;
    cur    = '{addr: 32'd0, dly: 0, ack: 1'b0, err: 1'b0, data: 32'd0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active  = 1'b0;
        stbcnt  = 0;
        wbm_ack = 1'b0;
        wbm_err = 1'b0;
        wbm_dat = 32'd0;
      end else if (wbm_stb) begin
        if (!active) begin
          active = 1'b1;
          stbcnt = 0;
          if (slv_q.size() == 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL unexpected_stb: stb=1 at adr 0x%08h, want no bus access", wbm_adr);
            cur = '{addr: wbm_adr, dly: 0, ack: 1'b0, err: 1'b1, data: 32'd0};
          end else begin
            cur = slv_q.pop_front();
          end
          chk("wb_cyc", 32'(wbm_cyc), 32'd1);
          chk("wb_we_sel", {27'd0, wbm_we, wbm_sel}, 32'h0000_000F);
        end else begin
          stbcnt++;
        end
        chk("wb_adr", wbm_adr, cur.addr);
        last_stb_len = stbcnt + 1;
        wbm_ack = cur.ack && (stbcnt == cur.dly);
        wbm_err = cur.err && (stbcnt == cur.dly);
        wbm_dat = cur.data;
      end else begin
        active  = 1'b0;
        wbm_ack = 1'b0;
        wbm_err = 1'b0;
      end
    end
  end

  // Response monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (imem_resp != RESP_NOTRDY) begin
          n_resp_seen++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL stray_resp: resp %0d rdata 0x%08h, want no response", imem_resp, imem_rdata);
          end else begin
            e = exp_q.pop_front();
            chk("resp_code", 32'(imem_resp), 32'(e.resp));
            chk("resp_rdata", imem_rdata, e.rdata);
            if (e.lat >= 0) chk("resp_latency", 32'(cyc_n - e.acc), 32'(e.lat));
          end
        end else begin
          chk("rdata_zero_idle", imem_rdata, 32'd0);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1 ms, want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc_a, acc_b, acc_c, bad, n0;

    vt[0] = '{cmd:1'b0, addr:32'h0001_0040, dly:0, ack:1'b1, err:1'b0, data:32'hDEAD_BEEF,
              exp_resp:RESP_OK, exp_rdata:32'hDEAD_BEEF, exp_lat:2, exp_stb:1};
    vt[1] = '{cmd:1'b1, addr:32'h0000_0200, dly:0, ack:1'b0, err:1'b0, data:32'h0,
              exp_resp:RESP_ER, exp_rdata:32'h0, exp_lat:2, exp_stb:0};
    vt[2] = '{cmd:1'b0, addr:32'h0000_0300, dly:0, ack:1'b1, err:1'b1, data:32'h1111_1111,
              exp_resp:RESP_ER, exp_rdata:32'h0, exp_lat:2, exp_stb:1};
    vt[3] = '{cmd:1'b0, addr:32'h0000_0304, dly:0, ack:1'b1, err:1'b0, data:32'h1234_5678,
              exp_resp:RESP_OK, exp_rdata:32'h1234_5678, exp_lat:2, exp_stb:1};
    vt[4] = '{cmd:1'b0, addr:32'h0000_0400, dly:2, ack:1'b1, err:1'b0, data:32'hA5A5_5A5A,
              exp_resp:RESP_OK, exp_rdata:32'hA5A5_5A5A, exp_lat:4, exp_stb:3};
    vt[5] = '{cmd:1'b0, addr:32'h0000_0500, dly:1, ack:1'b0, err:1'b1, data:32'h0BAD_F00D,
              exp_resp:RESP_ER, exp_rdata:32'h0, exp_lat:3, exp_stb:2};
    vt[6] = '{cmd:1'b0, addr:32'h0000_0600, dly:0, ack:1'b0, err:1'b0, data:32'h7777_7777,
              exp_resp:RESP_ER, exp_rdata:32'h0, exp_lat:6, exp_stb:5};
    vt[7] = '{cmd:1'b0, addr:32'h0000_0604, dly:4, ack:1'b1, err:1'b0, data:32'h600D_CAFE,
              exp_resp:RESP_OK, exp_rdata:32'h600D_CAFE, exp_lat:6, exp_stb:5};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ack", 32'(imem_req_ack), 32'd1);
    chk("rst_cyc_stb", {30'd0, wbm_cyc, wbm_stb}, 32'd0);
    chk("rst_resp", 32'(imem_resp), 32'(RESP_NOTRDY));
    chk("rst_rdata", imem_rdata, 32'd0);
    chk("rst_z_stb", 32'(z_stb), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ack", 32'(imem_req_ack), 32'd1);
    chk("post_rst_stb", 32'(wbm_stb), 32'd0);

    // Single fetches from the table
    for (int i = 0; i < 8; i++) begin
      last_stb_len = 0;
      if (!vt[i].cmd)
        slv_q.push_back('{addr: vt[i].addr, dly: vt[i].dly, ack: vt[i].ack,
                          err: vt[i].err, data: vt[i].data});
      send(vt[i].cmd, vt[i].addr, vt[i].exp_resp, vt[i].exp_rdata, vt[i].exp_lat, acc_a);
      drain();
      chk($sformatf("vec%0d_stb_len", i), 32'(last_stb_len), 32'(vt[i].exp_stb));
    end

    // Two zero-wait fetches back to back: one answer every two cycles
    slv_q.push_back('{addr: 32'h0000_1000, dly: 0, ack: 1'b1, err: 1'b0, data: 32'hC0DE_0001});
    slv_q.push_back('{addr: 32'h0000_1004, dly: 0, ack: 1'b1, err: 1'b0, data: 32'hC0DE_0002});
    send(1'b0, 32'h0000_1000, RESP_OK, 32'hC0DE_0001, 2, acc_a);
    send(1'b0, 32'h0000_1004, RESP_OK, 32'hC0DE_0002, 3, acc_b);
    drain();

    // Three back to back with a 3-cycle slave: the third waits for the first answer
    slv_q.push_back('{addr: 32'h0000_0100, dly: 3, ack: 1'b1, err: 1'b0, data: 32'h0000_0A01});
    slv_q.push_back('{addr: 32'h0000_0104, dly: 3, ack: 1'b1, err: 1'b0, data: 32'h0000_0A02});
    slv_q.push_back('{addr: 32'h0000_0108, dly: 3, ack: 1'b1, err: 1'b0, data: 32'h0000_0A03});
    send(1'b0, 32'h0000_0100, RESP_OK, 32'h0000_0A01, 5, acc_a);
    send(1'b0, 32'h0000_0104, RESP_OK, 32'h0000_0A02, 9, acc_b);
    send(1'b0, 32'h0000_0108, RESP_OK, 32'h0000_0A03, 9, acc_c);
    chk("backpressure_accept_gap", 32'(acc_c - acc_a), 32'd6);
    drain();

    // Disabled timeout: strobe stays up well past the 8-bit counter range
    @(negedge clk);
    z_req  = 1'b1;
    z_cmd  = 1'b0;
    z_addr = 32'h0000_0900;
    chk("t0_req_ack", 32'(z_req_ack), 32'd1);
    @(posedge clk);
    #1 z_req = 1'b0;
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (z_stb !== 1'b1 || z_cyc !== 1'b1 || z_resp !== RESP_NOTRDY) bad++;
    end
    chk("t0_stb_held_cycles_bad", 32'(bad), 32'd0);
    chk("t0_adr", z_adr, 32'h0000_0900);

    // Reset in the middle of a bus access with two entries queued
    slv_q.push_back('{addr: 32'h0000_0700, dly: 0, ack: 1'b0, err: 1'b0, data: 32'h0});
    send(1'b0, 32'h0000_0700, RESP_ER, 32'h0, -1, acc_a);
    send(1'b0, 32'h0000_0704, RESP_ER, 32'h0, -1, acc_b);
    chk("full_req_ack", 32'(imem_req_ack), 32'd0);
    chk("bus_before_rst", 32'(wbm_stb), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_cyc_stb", {30'd0, wbm_cyc, wbm_stb}, 32'd0);
    chk("rst_mid_resp", 32'(imem_resp), 32'(RESP_NOTRDY));
    chk("rst_mid_z_stb", 32'(z_stb), 32'd0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    slv_q.delete();
    rst_n = 1'b1;
    #1;
    chk("rst_rel_req_ack", 32'(imem_req_ack), 32'd1);
    n0 = n_resp_seen;
    repeat (10) @(negedge clk);
    chk("no_resp_after_rst", 32'(n_resp_seen - n0), 32'd0);
    chk("no_stb_after_rst", 32'(wbm_stb), 32'd0);

    // Recovery fetch
    slv_q.push_back('{addr: 32'h0000_0800, dly: 0, ack: 1'b1, err: 1'b0, data: 32'hCAFE_F00D});
    send(1'b0, 32'h0000_0800, RESP_OK, 32'hCAFE_F00D, 2, acc_a);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_ycr1_imem_wb_bridge
`default_nettype wire
